// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the unified instruction/data memory responder.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Word request/response port between the core's memory address mux (master) and the responder (slave).
interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, registered read, no reset (contents survive rst).
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: accepts one request, waits LATENCY cycles, pulses resp_valid.
//   state    | meaning
//   MEM_IDLE | ready; a valid request is accepted at the next edge
//   MEM_WAIT | counting down LATENCY-1..0; commit/read happens leaving this state
//   MEM_RESP | resp_valid high for this one cycle
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam int               CNT_W    = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_responder: LATENCY must be at least 1");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of two >= 4");
    end

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              mis_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              go_resp;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_resp   = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = MEM_RESP;
                    go_resp   = 1'b1;
                end
            end
            MEM_RESP: state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    assign bus.req_ready = (state == MEM_IDLE);

    // The RAM read port is addressed straight from the request while idle, so a
    // LATENCY=1 load already has its word registered by the WAIT->RESP edge.
    assign ram_idx     = (state == MEM_IDLE) ? bus.req_addr[IDX_W+1:2] : idx_q;
    assign ram_we      = go_resp & we_q & ~mis_q;
    assign unused_addr = ^bus.req_addr[WORD_W-1:IDX_W+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            we_q           <= 1'b0;
            mis_q          <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            bus.resp_valid <= go_resp;
            bus.resp_err   <= go_resp & mis_q;
            if (state == MEM_IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                mis_q   <= (bus.req_addr[1:0] != 2'b00);
                idx_q   <= bus.req_addr[IDX_W+1:2];
                wdata_q <= bus.req_wdata;
                cnt     <= CNT_LOAD;
            end else if (state == MEM_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (go_resp && !we_q && !mis_q) begin
                bus.resp_rdata <= ram_rdata;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a word-array model,
// on a LATENCY=2 / 1024-word build and a LATENCY=1 / 16-word build.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH_A = 1024;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 16;
    localparam int LAT_B   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    logic [31:0] last_rd [2];

    logic        o_ready, o_rv, o_err;
    logic [31:0] o_rd;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(int sel);
        return (sel == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int depth_of(int sel);
        return (sel == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    task automatic drive(int sel, logic v, logic we, logic [31:0] addr, logic [31:0] wd);
        if (sel == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wd;
        end
    endtask

    task automatic sample(int sel);
        if (sel == 0) begin
            o_ready = bus_a.req_ready; o_rv = bus_a.resp_valid; o_err = bus_a.resp_err; o_rd = bus_a.resp_rdata;
        end else begin
            o_ready = bus_b.req_ready; o_rv = bus_b.resp_valid; o_err = bus_b.resp_err; o_rd = bus_b.resp_rdata;
        end
    endtask

    // Reference: a word array indexed modulo depth; misaligned requests touch nothing.
    task automatic model(int sel, logic we, logic [31:0] addr, logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        int idx;
        idx = int'((addr >> 2) & 32'(depth_of(sel) - 1));
        err = (addr[1:0] != 2'b00);
        rd  = last_rd[sel];
        if (!err) begin
            if (we) begin
                if (sel == 0) mdl_a[idx] = wd; else mdl_b[idx] = wd;
            end else begin
                rd = (sel == 0) ? mdl_a[idx] : mdl_b[idx];
                last_rd[sel] = rd;
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr(int sel, int max_idx, bit allow_mis);
        logic [31:0] a;
        a = 32'($urandom_range(0, max_idx)) << 2;
        a = a + 32'($urandom_range(0, 7)) * 32'(depth_of(sel) * 4);
        if (allow_mis && $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // One transaction occupies LATENCY+2 cycles: IDLE, LATENCY WAIT cycles, RESP.
    // Called at a negedge; returns at the negedge where the responder is ready again.
    task automatic xact(int sel, logic we, logic [31:0] addr, logic [31:0] wd, string tag);
        logic        e_err;
        logic [31:0] e_rd;
        int          l;
        int          guard;
        l = lat_of(sel);
        guard = 0;
        sample(sel);
        while (!o_ready && guard < 20) begin
            @(negedge clk);
            sample(sel);
            guard++;
        end
        check({tag, ".ready_at_issue"}, 32'(o_ready), 32'd1);
        drive(sel, 1'b1, we, addr, wd);
        model(sel, we, addr, wd, e_err, e_rd);
        for (int k = 1; k <= l + 2; k++) begin
            @(negedge clk);
            if (k == 1) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
            sample(sel);
            check({tag, ".resp_valid"}, 32'(o_rv), 32'(k == l + 1));
            check({tag, ".req_ready"}, 32'(o_ready), 32'(k == l + 2));
            if (k == l + 1) begin
                check({tag, ".resp_err"}, 32'(o_err), 32'(e_err));
                check({tag, ".resp_rdata"}, o_rd, e_rd);
            end
        end
    endtask

    // req_valid held high with fresh addresses every cycle; the model decides which
    // cycles are accepted purely from the occupancy rule.
    task automatic busy(int sel, int ncyc, bit loads_only, string tag);
        int          l;
        int          p;
        int          next_free;
        int          n_resp;
        int          resp_at [$];
        logic [31:0] q_rd [$];
        logic        q_err [$];
        l = lat_of(sel);
        p = l + 2;
        next_free = 0;
        n_resp = 0;
        for (int k = 0; k < ncyc + p; k++) begin
            logic        v, we, e_err, exp_rv;
            logic [31:0] a, wd, e_rd;
            sample(sel);
            check({tag, ".req_ready"}, 32'(o_ready), 32'(k >= next_free));
            exp_rv = (resp_at.size() > 0 && resp_at[0] == k);
            check({tag, ".resp_valid"}, 32'(o_rv), 32'(exp_rv));
            if (o_rv) n_resp++;
            if (exp_rv) begin
                check({tag, ".resp_rdata"}, o_rd, q_rd[0]);
                check({tag, ".resp_err"}, 32'(o_err), 32'(q_err[0]));
                void'(resp_at.pop_front());
                void'(q_rd.pop_front());
                void'(q_err.pop_front());
            end
            v  = (k < ncyc);
            we = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
            a  = rnd_addr(sel, 15, 1'b1);
            wd = $urandom;
            drive(sel, v, we, a, wd);
            if (v && k >= next_free) begin
                model(sel, we, a, wd, e_err, e_rd);
                resp_at.push_back(k + l + 1);
                q_rd.push_back(e_rd);
                q_err.push_back(e_err);
                next_free = k + p;
            end
            @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        check({tag, ".n_resp"}, 32'(n_resp), 32'((ncyc + p - 1) / p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s);
            check("rst.req_ready", 32'(o_ready), 32'd1);
            check("rst.resp_valid", 32'(o_rv), 32'd0);
            check("rst.resp_err", 32'(o_err), 32'd0);
            check("rst.resp_rdata", o_rd, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        sample(0);
        check("post_rst.req_ready", 32'(o_ready), 32'd1);

        for (int i = 0; i < 16; i++) xact(0, 1'b1, 32'(i * 4), $urandom, "init_a");
        xact(0, 1'b1, 32'h14, 32'hDEADBEEF, "store_5");
        xact(0, 1'b0, 32'h14, 32'd0, "load_5");

        xact(0, 1'b1, 32'h40, 32'hCAFEF00D, "store_40");
        xact(0, 1'b0, 32'h40, 32'd0, "load_40");
        xact(0, 1'b0, 32'h40 + 32'(4 * DEPTH_A), 32'd0, "load_alias");

        xact(0, 1'b1, 32'h42, 32'h1, "mis_store");
        xact(0, 1'b0, 32'h40, 32'd0, "load_after_mis");
        xact(0, 1'b0, 32'h14, 32'd0, "load_5_again");
        xact(0, 1'b0, 32'h41, 32'd0, "mis_load");

        // Store aborted by rst while in WAIT: no response, no commit, outputs back to reset.
        drive(0, 1'b1, 1'b1, 32'h8, 32'h5A5A1234);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        sample(0);
        check("abort.busy", 32'(o_ready), 32'd0);
        rst = 1'b1;
        #1;
        sample(0);
        check("abort.req_ready", 32'(o_ready), 32'd1);
        check("abort.resp_valid", 32'(o_rv), 32'd0);
        check("abort.resp_err", 32'(o_err), 32'd0);
        check("abort.resp_rdata", o_rd, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sample(0);
            check("abort.no_resp", 32'(o_rv), 32'd0);
            check("abort.idle", 32'(o_ready), 32'd1);
        end
        xact(0, 1'b0, 32'h8, 32'd0, "abort.load_8");

        for (int i = 0; i < 40; i++) begin
            xact(0, 1'($urandom_range(0, 1)), rnd_addr(0, 15, 1'b1), $urandom, "rand_a");
        end
        busy(0, 24, 1'b0, "busy_a");
        xact(0, 1'b0, 32'h40, 32'd0, "load_40_final");

        for (int i = 0; i < 16; i++) xact(1, 1'b1, 32'(i * 4), $urandom, "init_b");
        busy(1, 30, 1'b1, "b2b_b");
        xact(1, 1'b0, 32'h2, 32'd0, "mis_load_b");
        busy(1, 15, 1'b0, "busy_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
